vec_instr_rx: RTL and testbench

- Coprocessor-side receiver for the scalar-core to vector-coprocessor instruction interface.
- Accepts OP-V instructions from the RISC-V core into a small FIFO.
- For vector-scalar and config forms, reads the rs1 scalar operand back from the core via the xreg read port.
- Dispatches instruction plus scalar operand to the vector decode stage with a valid/ready handshake.

---
 rtl/vec_instr_rx.sv | 151 +++++++++++++++
 tb/tb_vec_instr_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_instr_rx.sv
// rtl/vec_instr_rx.sv - OP-V instruction receiver: FIFO, scalar operand fetch, dispatch
// Optional VEC_RX_VSETVL_RS2_EN: vsetvl also fetches rs2 onto op_scalar2.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REGFILE_BITS
`define REGFILE_BITS 5
`endif

module vec_instr_rx #(
  parameter int DEPTH    = 4,
  parameter int XREG_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              v_instr,
  input  logic                     v_instr_valid,
  output logic                     v_instr_stall,
  output logic [`REGFILE_BITS-1:0] v_rd_xreg_addr,
  input  logic [`WORD_WIDTH-1:0]   xreg_in,
  output logic [31:0]              op_instr,
  output logic [`WORD_WIDTH-1:0]   op_scalar,
`ifdef VEC_RX_VSETVL_RS2_EN
  output logic [`WORD_WIDTH-1:0]   op_scalar2,
`endif
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     illegal_instr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [6:0] OPV = 7'b1010111;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [2:0] LAT_M1 = 3'(XREG_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, FETCH2, OUT} state_t;

  state_t state, state_n;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [2:0]    wait_cnt;
  logic [31:0]   head;
  logic          full, empty, push, pop, head_needs_scalar;

  assign head              = mem[rd_ptr];
  // funct3 100..111 (OPIVX, OPFVF, OPMVX, OPCFG) all carry an rs1 operand
  assign head_needs_scalar = head[14];
  assign full              = (count == FULL_CNT);
  assign empty             = (count == '0);
  assign push              = v_instr_valid && (v_instr[6:0] == OPV) && !full;
  assign pop               = (state == OUT) && op_ready;

  assign v_instr_stall = full;
  assign fifo_count    = count;
  assign op_valid      = (state == OUT);

`ifdef VEC_RX_VSETVL_RS2_EN
  localparam logic [2:0] LAT_FULL = 3'(XREG_LAT);
  logic head_vsetvl;
  assign head_vsetvl = (head[14:12] == 3'b111) && head[31] && !head[30];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= v_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!empty) state_n = head_needs_scalar ? FETCH : OUT;
`ifdef VEC_RX_VSETVL_RS2_EN
      FETCH:  if (wait_cnt == 3'd0) state_n = head_vsetvl ? FETCH2 : OUT;
`else
      FETCH:  if (wait_cnt == 3'd0) state_n = OUT;
`endif
      FETCH2: if (wait_cnt == 3'd0) state_n = OUT;
      OUT:    if (op_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt       <= '0;
      v_rd_xreg_addr <= '0;
      op_instr       <= '0;
      op_scalar      <= '0;
      illegal_instr  <= 1'b0;
`ifdef VEC_RX_VSETVL_RS2_EN
      op_scalar2     <= '0;
`endif
    end else begin
      illegal_instr <= v_instr_valid && (v_instr[6:0] != OPV);
      case (state)
        IDLE: if (!empty) begin
          op_instr <= head;
`ifdef VEC_RX_VSETVL_RS2_EN
          op_scalar2 <= '0;
`endif
          if (head_needs_scalar) begin
            v_rd_xreg_addr <= `REGFILE_BITS'(head[19:15]);
            wait_cnt       <= LAT_M1;
          end else begin
            op_scalar <= '0;
          end
        end
        FETCH: if (wait_cnt == 3'd0) begin
          op_scalar <= xreg_in;
`ifdef VEC_RX_VSETVL_RS2_EN
          // one extra cycle to present the rs2 index before the latency window
          if (head_vsetvl) begin
            v_rd_xreg_addr <= `REGFILE_BITS'(head[24:20]);
            wait_cnt       <= LAT_FULL;
          end
`endif
        end else begin
          wait_cnt <= wait_cnt - 3'd1;
        end
`ifdef VEC_RX_VSETVL_RS2_EN
        FETCH2: if (wait_cnt == 3'd0) op_scalar2 <= xreg_in;
                else wait_cnt <= wait_cnt - 3'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_instr_rx.sv
// tb/tb_vec_instr_rx.sv - self-checking bench for vec_instr_rx
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REGFILE_BITS
`define REGFILE_BITS 5
`endif

module tb_vec_instr_rx;
  localparam int DEPTH = 4;

  bit clk = 1'b0;
  logic rst, v_instr_valid, op_ready;
  logic [31:0] v_instr;
  logic v_instr_stall, op_valid, illegal_instr;
  logic [`REGFILE_BITS-1:0] v_rd_xreg_addr;
  logic [`WORD_WIDTH-1:0] xreg_in, op_scalar;
  logic [31:0] op_instr;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef VEC_RX_VSETVL_RS2_EN
  logic [`WORD_WIDTH-1:0] op_scalar2;
`endif

  logic [31:0] regs [32];
  assign xreg_in = regs[v_rd_xreg_addr];

  vec_instr_rx #(.DEPTH(DEPTH), .XREG_LAT(1)) dut (
    .clk(clk), .rst(rst), .v_instr(v_instr), .v_instr_valid(v_instr_valid),
    .v_instr_stall(v_instr_stall), .v_rd_xreg_addr(v_rd_xreg_addr), .xreg_in(xreg_in),
    .op_instr(op_instr), .op_scalar(op_scalar),
`ifdef VEC_RX_VSETVL_RS2_EN
    .op_scalar2(op_scalar2),
`endif
    .op_valid(op_valid), .op_ready(op_ready), .illegal_instr(illegal_instr),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] vd);
    return {6'b000000, 1'b1, 5'd2, rs1, f3, vd, 7'b1010111};
  endfunction

  // funct3 of 100 and above names a vector-scalar or config form
  function automatic logic [31:0] exp_scalar(input logic [31:0] w);
    return (w[14:12] >= 3'b100) ? regs[w[19:15]] : 32'h0;
  endfunction

  // reference model: queue of accepted instructions, pending illegal pulse
  logic [31:0] m_q[$];
  logic [31:0] disp_q[$];
  logic m_ill = 1'b0;
  logic acc;

  always @(negedge clk) begin
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("stall", 32'(v_instr_stall), 32'(m_q.size() == DEPTH));
    chk("illegal_instr", 32'(illegal_instr), 32'(m_ill));
    chk("spurious_valid", 32'(op_valid && (m_q.size() == 0)), 32'h0);
    if (op_valid && m_q.size() != 0) begin
      chk("op_instr", op_instr, m_q[0]);
      chk("op_scalar", op_scalar, exp_scalar(m_q[0]));
`ifdef VEC_RX_VSETVL_RS2_EN
      chk("op_scalar2", op_scalar2,
          (m_q[0][14:12] == 3'b111 && m_q[0][31:30] == 2'b10) ? regs[m_q[0][24:20]] : 32'h0);
`endif
    end
    if (rst) begin
      m_q.delete();
      m_ill = 1'b0;
    end else begin
      acc   = v_instr_valid && (v_instr[6:0] == 7'b1010111) && (m_q.size() < DEPTH);
      m_ill = v_instr_valid && (v_instr[6:0] != 7'b1010111);
      if (op_valid && op_ready && m_q.size() != 0) begin
        disp_q.push_back(op_instr);
        void'(m_q.pop_front());
      end
      if (acc) m_q.push_back(v_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    v_instr = w;
    v_instr_valid = 1'b1;
    tick();
    v_instr_valid = 1'b0;
  endtask

  task automatic meas_lat(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (op_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fifo_count == 0 && !op_valid) break;
    end
    chk(nm, 32'(k < 100), 32'h1);
    tick();
  endtask

  localparam logic [31:0] VV  = 32'h02208057;
  localparam logic [31:0] VX5 = 32'h0222C0D7;
  logic [31:0] full_w [5];
  int lat;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    full_w[0] = 32'h02208057; full_w[1] = 32'h022080D7; full_w[2] = 32'h02208157;
    full_w[3] = 32'h022081D7; full_w[4] = 32'h02208257;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i + 32'h100;
    regs[5] = 32'hDEADBEEF;
    regs[1] = 32'h7;
    regs[2] = 32'hD0;
    rst = 1'b1; v_instr = '0; v_instr_valid = 1'b0; op_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_addr", 32'(v_rd_xreg_addr), 32'h0);
    chk("rst_op_instr", op_instr, 32'h0);
    chk("rst_op_scalar", op_scalar, 32'h0);
    tick();

    // non-scalar latency
    op_ready = 1'b1;
    push_word(VV);
    meas_lat(lat);
    chk("lat_vv", 32'(lat), 32'd2);
    chk("vv_instr", op_instr, 32'h02208057);
    chk("vv_scalar", op_scalar, 32'h0);
    tick();
    @(negedge clk);
    chk("vv_count_after", 32'(fifo_count), 32'h0);
    chk("vv_valid_after", 32'(op_valid), 32'h0);
    tick();

    // scalar latency and operand read
    push_word(VX5);
    meas_lat(lat);
    chk("lat_vx", 32'(lat), 32'd3);
    chk("vx_addr", 32'(v_rd_xreg_addr), 32'd5);
    chk("vx_scalar", op_scalar, 32'hDEADBEEF);
    tick();
    drain("drain_vx");

    // fill to full with op_ready low; fifth push dropped
    disp_q.delete();
    op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v_instr = full_w[i];
      v_instr_valid = 1'b1;
      tick();
    end
    v_instr_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_stall", 32'(v_instr_stall), 32'h1);
    tick();
    op_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_drop", 32'(v_instr_stall), 32'h0);
    chk("count_after_pop", 32'(fifo_count), 32'd3);
    drain("drain_full");
    chk("full_disp_n", 32'(disp_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("full_order", (disp_q.size() > i) ? disp_q[i] : 32'hFFFF_FFFF, full_w[i]);

    // illegal word
    push_word(32'h00000013);
    @(negedge clk);
    chk("illegal_pulse", 32'(illegal_instr), 32'h1);
    chk("illegal_count", 32'(fifo_count), 32'h0);
    tick();
    @(negedge clk);
    chk("illegal_clear", 32'(illegal_instr), 32'h0);
    chk("illegal_no_disp", 32'(op_valid), 32'h0);
    tick();

    // reset while fetching with two queued
    v_instr = VX5; v_instr_valid = 1'b1;
    tick();
    v_instr = 32'h0220C0D7;
    tick();
    v_instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_addr", 32'(v_rd_xreg_addr), 32'd5);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(fifo_count), 32'h0);
    chk("post_rst_valid", 32'(op_valid), 32'h0);
    chk("post_rst_addr", 32'(v_rd_xreg_addr), 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("post_rst_idle", 32'(op_valid), 32'h0);
    tick();
    push_word(VV);
    meas_lat(lat);
    chk("lat_after_rst", 32'(lat), 32'd2);
    chk("instr_after_rst", op_instr, 32'h02208057);
    tick();
    drain("drain_rst");

    // mixed forms with back-pressure
    for (int i = 0; i < 16; i++) begin
      v_instr = mk(3'(i), 5'((i * 3) % 32), 5'(i));
      v_instr_valid = (i % 4 != 3);
      op_ready = (i % 3 != 0);
      tick();
    end
    v_instr_valid = 1'b0;
    op_ready = 1'b1;
    drain("drain_mixed");
    chk("model_empty", 32'(m_q.size()), 32'h0);

`ifdef VEC_RX_VSETVL_RS2_EN
    push_word(32'h8020F1D7);
    meas_lat(lat);
    chk("vsetvl_lat_ok", 32'(lat > 0), 32'h1);
    chk("vsetvl_rs1", op_scalar, 32'h7);
    chk("vsetvl_rs2", op_scalar2, 32'hD0);
    tick();
    drain("drain_vsetvl");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
